hist_dump_reader: RTL
=====================

# hist_dump_reader

Readout engine for the time-correlation histogram memory: on a host command it walks all 128 bins of the 32-bit histogram RAM, serializes each bin into bytes and streams them over a valid/ready byte interface to the UART transmitter. A dump is framed as a header, the bin payload and a checksum. Clear-after-read mode zeroes each bin once it has been captured. The block sits between the histogram memory's read/clear port and the host TX path.

## Interface
- ADDR_W, 7, bin address width
- N_BINS, 128, number of bins dumped (2^ADDR_W)
- DATA_W, 32, bin width (fixed at 4 bytes)
- HDR_BYTE, 8'hA5, frame header byte
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- Command  in  2  host command: 2'b10 dump, 2'b11 dump+clear, 2'b01 abort, 2'b00 idle
- rd_en  out  1  read strobe to histogram RAM
- rd_addr  out  ADDR_W  bin address (read and clear)
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en
- clr_en  out  1  write-zero strobe to bin rd_addr
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse, dump completed normally

## Operation
- Reset: state IDLE; rd_en, clr_en, tx_valid, busy, done = 0; rd_addr = 0; tx_data = 0; checksum = 0; prev_cmd = 0.
- Start: edge-triggered. prev_cmd registers Command every cycle. Start when in IDLE, Command ∈ {10, 11} and Command != prev_cmd. Holding Command does not retrigger. Start commands while busy are ignored. The clear mode is latched at start.
- States: IDLE -> HDR -> FETCH -> WAIT -> BYTE(0..3) -> (FETCH | CSUM) -> IDLE.
- HDR: tx_data = HDR_BYTE, tx_valid = 1 until the handshake. Checksum is cleared at start.
- FETCH: rd_en = 1 for one cycle at the current rd_addr.
- WAIT: capture rd_data into the shift register. In clear mode, clr_en = 1 for this one cycle with rd_addr unchanged.
- BYTE k: present data byte k, LSB first (bits 8k+7:8k). On the handshake, XOR the byte into checksum. After k = 3: if rd_addr == N_BINS-1, go to CSUM; otherwise increment rd_addr and go to FETCH.
- CSUM: tx_data = XOR of all 512 payload bytes (header excluded). On the handshake: done = 1 for one cycle, busy = 0, rd_addr = 0, go to IDLE.
- Handshake: a byte transfers on a cycle with tx_valid && tx_ready. While tx_valid && !tx_ready, tx_data is held stable and tx_valid stays high; neither may change until the transfer.
- Abort (Command == 01 while busy):
  - If no byte is pending, go to IDLE on the next edge.
  - If a byte is pending, complete that byte's handshake, then go to IDLE.
  - On abort: no done pulse, clr_en never asserted afterwards, rd_addr = 0.
  - Bins already cleared stay cleared.
- rst mid-dump returns every output to its reset value on the next edge, with no further bytes.
- busy = 1 from the cycle after start through the CSUM handshake cycle.

## Timing
- Start sampled at edge k: busy = 1 and tx_valid = 1 (HDR) from cycle k+1.
- rd_data is sampled one cycle after rd_en (registered RAM, 1-cycle latency).
- With tx_ready tied high: 1 cycle HDR, 6 cycles per bin (FETCH, WAIT, 4 bytes), 1 cycle CSUM = 770 cycles busy. done pulses on the edge ending the CSUM cycle.
- Backpressure stretches only the BYTE/HDR/CSUM states. FETCH/WAIT are always one cycle each.
- rd_addr wraps only via the explicit reset to 0 after CSUM or abort; it never increments past N_BINS-1.

## Test plan
- All bins 0, Command 00->10, tx_ready = 1 -> byte stream A5, 512×00, 00. busy high for exactly 770 cycles. One done pulse. clr_en never asserted.
- Bin 5 = 32'hDEADBEEF, others 0 -> payload bytes 20..23 = EF BE AD DE. Checksum = 8'h22.
- Command 00->11 with bin i = i+1 -> bytes correct, clr_en pulses 128 times with rd_addr 0..127 in WAIT. A second dump returns all zeros.
- Random tx_ready (50%) -> tx_data/tx_valid stable during stalls. Byte sequence identical to the no-stall run.
- Command held at 10 for 2000 cycles -> exactly one dump. Command 00->10 during busy -> ignored.
- Abort: Command 01 during bin 40 with tx_ready = 0 at byte 2 -> byte 2 completes once tx_ready rises, then IDLE. No done, no CSUM byte, rd_addr = 0. rst asserted mid-dump -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/hist_dump_reader.sv
// hist_dump_reader: walks every bin of the histogram RAM on a host command and
// streams a framed dump (header, 4 bytes per bin LSB first, XOR checksum) over
// a valid/ready byte interface. Optional clear-after-read zeroes each captured bin.
module hist_dump_reader #(
   parameter int         ADDR_W   = 7,
   parameter int         N_BINS   = 128,
   parameter int         DATA_W   = 32,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_command,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_clr_en,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_FETCH,
      S_WAIT,
      S_BYTE,
      S_CSUM
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DATA_W-1:0] r_shift;
   logic [1:0]        r_byte_idx;
   logic [7:0]        r_csum;
   logic [1:0]        r_prev_cmd;
   logic              r_clear_mode;
   logic              r_abort;
   logic              r_done;

   logic              w_start;
   logic              w_abort_cmd;
   logic              w_aborting;
   logic              w_tx_valid;
   logic              w_xfer;
   logic              w_to_idle;
   logic [7:0]        w_byte;

   // Start is edge-triggered on the command code; abort only matters mid-dump.
   assign w_start     = (r_state == S_IDLE) && i_command[1] && (i_command != r_prev_cmd);
   assign w_abort_cmd = (r_state != S_IDLE) && (i_command == 2'b01);
   assign w_aborting  = w_abort_cmd || r_abort;
   assign w_tx_valid  = (r_state == S_HDR) || (r_state == S_BYTE) || (r_state == S_CSUM);
   assign w_xfer      = w_tx_valid && i_tx_ready;
   assign w_byte      = r_shift[{r_byte_idx, 3'b000} +: 8];
   assign w_to_idle   = (r_state != S_IDLE) && (w_next == S_IDLE);

   assign o_tx_valid  = w_tx_valid;
   assign o_rd_addr   = r_rd_addr;
   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;

   // State register.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values of the others.
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode plus RAM strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the case leaves it unassigned (which would infer a latch).
      w_next   = r_state;
      o_rd_en  = 1'b0;
      o_clr_en = 1'b0;
      unique case (r_state)
         S_IDLE: if (w_start) w_next = S_HDR;
         S_HDR: begin
            if (w_xfer) w_next = w_aborting ? S_IDLE : S_FETCH;
         end
         S_FETCH: begin
            o_rd_en = 1'b1;
            w_next  = w_abort_cmd ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            o_clr_en = r_clear_mode && !w_abort_cmd;
            w_next   = w_abort_cmd ? S_IDLE : S_BYTE;
         end
         S_BYTE: begin
            if (w_xfer) begin
               if (w_aborting)               w_next = S_IDLE;
               else if (r_byte_idx == 2'd3)  w_next = (r_rd_addr == LAST_ADDR) ? S_CSUM : S_FETCH;
            end
         end
         S_CSUM: if (w_xfer) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Byte presented to the transmitter; held by the state and data registers.
   always_comb begin
      o_tx_data = 8'h00;
      unique case (r_state)
         S_HDR:   o_tx_data = HDR_BYTE;
         S_BYTE:  o_tx_data = w_byte;
         S_CSUM:  o_tx_data = r_csum;
         default: o_tx_data = 8'h00;
      endcase
   end

   // Datapath: command history, bin address, captured word, checksum, done pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prev_cmd   <= 2'b00;
         r_rd_addr    <= '0;
         r_shift      <= '0;
         r_byte_idx   <= 2'd0;
         r_csum       <= 8'h00;
         r_clear_mode <= 1'b0;
         r_abort      <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_prev_cmd <= i_command;
         r_done     <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_clear_mode <= i_command[0];
                  r_csum       <= 8'h00;
                  r_rd_addr    <= '0;
                  r_byte_idx   <= 2'd0;
                  r_abort      <= 1'b0;
               end
            end
            S_WAIT: begin
               r_shift    <= i_rd_data;
               r_byte_idx <= 2'd0;
            end
            S_BYTE: begin
               if (w_xfer) begin
                  r_csum     <= r_csum ^ w_byte;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (r_byte_idx == 2'd3 && r_rd_addr != LAST_ADDR && !w_aborting)
                     r_rd_addr <= r_rd_addr + 1'b1;
               end
            end
            default: ;
         endcase
         // An abort during a stalled byte is remembered until that byte goes out.
         if (w_abort_cmd && w_tx_valid && !i_tx_ready) r_abort <= 1'b1;
         if (w_to_idle) begin
            r_rd_addr <= '0;
            r_abort   <= 1'b0;
            r_done    <= (r_state == S_CSUM) && !w_aborting;
         end
      end
   end

endmodule
